// File: rtl/flip_controller.sv
// Memory-game turn controller: shuffles via an external generator, tracks two-card flips, matches, moves.
// Card i sits at board[47-3i -: 3] and at bit (15-i) of face_up/matched, so card 0 is the MSB everywhere.
module flip_controller #(
  parameter int HIDE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_game,
  input  logic        sel_valid,
  input  logic [3:0]  sel_idx,
  output logic        rng_start,
  input  logic        rng_done,
  input  logic [47:0] rng_num,
  output logic [47:0] board,
  output logic [15:0] face_up,
  output logic [15:0] matched,
  output logic [3:0]  pairs,
  output logic [7:0]  moves,
  output logic        busy,
  output logic        game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHUFFLE,
    S_WAIT1,
    S_WAIT2,
    S_COMPARE,
    S_SHOW,
    S_DONE
  } state_t;

  localparam logic [7:0] HIDE_LOAD = 8'(HIDE_CYCLES);

  state_t      r_state, w_state_nxt;
  logic [47:0] r_board, w_board_nxt;
  logic [15:0] r_face_up, w_face_up_nxt;
  logic [15:0] r_matched, w_matched_nxt;
  logic [3:0]  r_pairs, w_pairs_nxt;
  logic [7:0]  r_moves, w_moves_nxt;
  logic [3:0]  r_first, w_first_nxt;
  logic [3:0]  r_second, w_second_nxt;
  logic [7:0]  r_hide_cnt, w_hide_cnt_nxt;
  logic        r_rng_start, w_rng_start_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_game_over, w_game_over_nxt;

  logic [15:0] w_sel_bit;
  logic [15:0] w_pair_bits;
  logic        w_sel_free;
  logic        w_vals_eq;

  function automatic logic [15:0] card_bit(input logic [3:0] idx);
    card_bit = 16'h8000 >> idx;
  endfunction

  function automatic logic [2:0] card_val(input logic [47:0] b, input logic [3:0] idx);
    logic [47:0] sh;
    sh       = b << (6'(idx) * 6'd3);
    card_val = sh[47:45];
  endfunction

  assign w_sel_bit   = card_bit(sel_idx);
  assign w_sel_free  = (r_face_up & w_sel_bit) == 16'h0000;
  assign w_pair_bits = card_bit(r_first) | card_bit(r_second);
  assign w_vals_eq   = card_val(r_board, r_first) == card_val(r_board, r_second);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_board     <= '0;
      r_face_up   <= '0;
      r_matched   <= '0;
      r_pairs     <= '0;
      r_moves     <= '0;
      r_first     <= '0;
      r_second    <= '0;
      r_hide_cnt  <= '0;
      r_rng_start <= 1'b0;
      r_busy      <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_board     <= w_board_nxt;
      r_face_up   <= w_face_up_nxt;
      r_matched   <= w_matched_nxt;
      r_pairs     <= w_pairs_nxt;
      r_moves     <= w_moves_nxt;
      r_first     <= w_first_nxt;
      r_second    <= w_second_nxt;
      r_hide_cnt  <= w_hide_cnt_nxt;
      r_rng_start <= w_rng_start_nxt;
      r_busy      <= w_busy_nxt;
      r_game_over <= w_game_over_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_board_nxt    = r_board;
    w_face_up_nxt  = r_face_up;
    w_matched_nxt  = r_matched;
    w_pairs_nxt    = r_pairs;
    w_moves_nxt    = r_moves;
    w_first_nxt    = r_first;
    w_second_nxt   = r_second;
    w_hide_cnt_nxt = r_hide_cnt;

    if (new_game) begin
      w_state_nxt   = S_SHUFFLE;
      w_face_up_nxt = '0;
      w_matched_nxt = '0;
      w_pairs_nxt   = '0;
      w_moves_nxt   = '0;
    end else begin
      case (r_state)
        S_SHUFFLE: begin
          if (rng_done) begin
            w_board_nxt = rng_num;
            w_state_nxt = S_WAIT1;
          end
        end
        S_WAIT1: begin
          if (sel_valid && w_sel_free) begin
            w_face_up_nxt = r_face_up | w_sel_bit;
            w_first_nxt   = sel_idx;
            w_state_nxt   = S_WAIT2;
          end
        end
        S_WAIT2: begin
          // The first card is already face-up, so reselecting it falls out here.
          if (sel_valid && w_sel_free) begin
            w_face_up_nxt = r_face_up | w_sel_bit;
            w_second_nxt  = sel_idx;
            w_moves_nxt   = (r_moves == 8'hFF) ? r_moves : r_moves + 8'd1;
            w_state_nxt   = S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (w_vals_eq) begin
            w_matched_nxt = r_matched | w_pair_bits;
            w_pairs_nxt   = r_pairs + 4'd1;
            w_state_nxt   = (r_pairs == 4'd7) ? S_DONE : S_WAIT1;
          end else begin
            w_hide_cnt_nxt = HIDE_LOAD;
            w_state_nxt    = S_SHOW;
          end
        end
        S_SHOW: begin
          if (r_hide_cnt <= 8'd1) begin
            w_face_up_nxt = r_face_up & ~w_pair_bits;
            w_state_nxt   = S_WAIT1;
          end else begin
            w_hide_cnt_nxt = r_hide_cnt - 8'd1;
          end
        end
        S_IDLE, S_DONE: begin
          w_state_nxt = r_state;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Status flags are decoded from the next state so they register alongside it.
  always_comb begin
    w_rng_start_nxt = (w_state_nxt == S_SHUFFLE);
    w_busy_nxt      = (w_state_nxt == S_SHUFFLE) || (w_state_nxt == S_COMPARE) ||
                      (w_state_nxt == S_SHOW);
    w_game_over_nxt = (w_state_nxt == S_DONE);
  end

  assign rng_start = r_rng_start;
  assign board     = r_board;
  assign face_up   = r_face_up;
  assign matched   = r_matched;
  assign pairs     = r_pairs;
  assign moves     = r_moves;
  assign busy      = r_busy;
  assign game_over = r_game_over;

endmodule
